// File: rtl/ir_key_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ir_key_pkg
// Desc    : Shared types, key codes and IR command lookup for the key decoder.
// Rev     : 1.0 - initial release
// ============================================================================
package ir_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_PUSH   = 2'd2,
        ST_HOLD   = 2'd3
    } ir_state_t;

    localparam logic [3:0] KEY_TARE  = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;
    localparam logic [3:0] KEY_UNIT  = 4'hD;

    // Returns {hit, key_id}; unmapped codes return all zeros.
    function automatic logic [4:0] ir_code_to_key(input logic [7:0] ir_code);
        logic [4:0] r_result;
        r_result = 5'd0;
        case (ir_code)
            8'h16:   r_result = {1'b1, 4'h0};
            8'h0C:   r_result = {1'b1, 4'h1};
            8'h18:   r_result = {1'b1, 4'h2};
            8'h5E:   r_result = {1'b1, 4'h3};
            8'h08:   r_result = {1'b1, 4'h4};
            8'h1C:   r_result = {1'b1, 4'h5};
            8'h5A:   r_result = {1'b1, 4'h6};
            8'h42:   r_result = {1'b1, 4'h7};
            8'h52:   r_result = {1'b1, 4'h8};
            8'h4A:   r_result = {1'b1, 4'h9};
            8'h45:   r_result = {1'b1, KEY_TARE};
            8'h46:   r_result = {1'b1, KEY_CLEAR};
            8'h40:   r_result = {1'b1, KEY_ENTER};
            8'h47:   r_result = {1'b1, KEY_UNIT};
            default: r_result = 5'd0;
        endcase
        return r_result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// Module  : key_fifo
// Desc    : First-word-fall-through queue; head is zero while empty.
// Rev     : 1.0 - initial release
// ============================================================================
module key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wr_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_pop;
    logic             w_push;
    logic             w_full;

    assign valid    = (r_level != '0);
    assign w_full   = (r_level == LVL_W'(DEPTH));
    assign w_pop    = rd_en && valid;
    // A pop frees the slot in the same cycle, so a full queue still accepts.
    assign wr_ready = !w_full || w_pop;
    assign w_push   = wr_en && wr_ready;
    assign level    = r_level;
    assign rd_data  = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ir_key_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ir_key_decoder
// Desc    : Turns IR receiver command frames into queued keypad key codes.
// Rev     : 1.0 - initial release
// ============================================================================
module ir_key_decoder
    import ir_key_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int UNK_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    code,
    input  logic                          press,
    input  logic                          key_ready,
    input  logic                          ovf_clr,
    output logic                          key_valid,
    output logic [3:0]                    key_id,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic [UNK_W-1:0]              unk_cnt
);

    ir_state_t        r_state;
    logic             r_press_d;
    logic [7:0]       r_code_q;
    logic [3:0]       r_key_q;
    logic             r_hit_q;
    logic             r_ovf;
    logic [UNK_W-1:0] r_unk_cnt;

    logic             w_edge;
    logic             w_push;
    logic             w_wr_ready;
    logic             w_drop;

    assign w_edge  = press && !r_press_d;
    assign w_push  = (r_state == ST_PUSH) && r_hit_q;
    assign w_drop  = w_push && !w_wr_ready;
    assign ovf     = r_ovf;
    assign unk_cnt = r_unk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_press_d <= 1'b0;
            r_code_q  <= '0;
            r_key_q   <= '0;
            r_hit_q   <= 1'b0;
            r_ovf     <= 1'b0;
            r_unk_cnt <= '0;
        end else begin
            r_press_d <= press;
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_code_q <= code;
                        r_state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    {r_hit_q, r_key_q} <= ir_code_to_key(r_code_q);
                    r_state            <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (!r_hit_q && (r_unk_cnt != {UNK_W{1'b1}})) begin
                        r_unk_cnt <= r_unk_cnt + UNK_W'(1);
                    end
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!press) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    key_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_push),
        .wr_data  (r_key_q),
        .rd_en    (key_ready),
        .rd_data  (key_id),
        .valid    (key_valid),
        .level    (level),
        .wr_ready (w_wr_ready)
    );

endmodule
`default_nettype wire

// File: doc/ir_key_decoder.md
IR_KEY_DECODER -- requirements
Module: ir_key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: key queue depth in entries, a power of two from 2 to 16.
REQ-002 Parameter UNK_W, default 8: width of the unknown-code counter.
REQ-003 clk  input  1  system clock (1 MHz, 1 us period), the single clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 code  input  8  command byte from the IR receiver; valid while press is high.
REQ-006 press  input  1  IR receiver key-pressed level, held high about 100 ms per frame.
REQ-007 key_ready  input  1  consumer accepts the head key this cycle.
REQ-008 ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 key_valid  output  1  queue non-empty; key_id holds the head entry.
REQ-010 key_id  output  4  decoded key: 0-9 digits, A=TARE, B=CLEAR, C=ENTER, D=UNIT.
REQ-011 level  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-012 ovf  output  1  sticky: a decoded key was dropped because the queue was full.
REQ-013 unk_cnt  output  UNK_W  saturating count of frames with an unmapped code.

Function
REQ-014 press is registered once into press_d; the edge condition is press=1 with press_d=0.
REQ-015 The FSM states are IDLE, LOOKUP, PUSH and HOLD.
REQ-016 IDLE -> LOOKUP on the edge condition; code is captured into code_q in the same cycle.
REQ-017 LOOKUP maps code_q through the key table (REQ-028) into a registered key_q and hit_q, then goes to PUSH.
REQ-018 PUSH with hit_q=1 writes key_q when there is space; otherwise it drops the key and sets ovf.
REQ-019 PUSH with hit_q=0 writes nothing and increments unk_cnt, saturating at all-ones.
REQ-020 PUSH always goes to HOLD; HOLD goes to IDLE on the first cycle press=0.
REQ-021 Edges that arrive in LOOKUP, PUSH or HOLD are ignored.
REQ-022 Latency: with the edge in cycle N, the entry is written at the end of N+2 and key_valid=1 in N+3 if the queue was empty.
REQ-023 The queue is a first-word-fall-through FIFO.
- key_valid equals (level != 0).
- Pop happens when key_valid and key_ready are both high.
- key_ready while key_valid=0 has no effect.
REQ-024 Full queue with a pop in the same cycle as a PUSH write: both proceed, level is unchanged and ovf is not set.
REQ-025 Empty queue with a write: key_valid rises the next cycle; there is no same-cycle bypass.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH.
REQ-027 ovf_clr clears ovf; when ovf_clr coincides with a new drop, the set wins.
REQ-028 Key table (code -> key_id); every other code is unmapped:
- 0x16->0, 0x0C->1, 0x18->2, 0x5E->3, 0x08->4
- 0x1C->5, 0x5A->6, 0x42->7, 0x52->8, 0x4A->9
- 0x45->A, 0x46->B, 0x40->C, 0x47->D
REQ-029 key_id is 0 whenever key_valid=0.

Reset
REQ-030 rst_n low asynchronously sets:
- FSM to IDLE, press_d=0, code_q=0, key_q=0, hit_q=0
- both pointers=0, level=0, key_valid=0, key_id=0, ovf=0, unk_cnt=0
REQ-031 Reset asserted in LOOKUP or PUSH discards the pending key; the FIFO contents are lost.
REQ-032 If press is already high when reset releases, press_d=0 lets the next cycle count as an edge.
- This is accepted: one decode occurs.

Structure
REQ-033 Package ir_key_pkg holds:
- the FSM state enum
- the key_id constants (KEY_TARE=4'hA, KEY_CLEAR=4'hB, KEY_ENTER=4'hC, KEY_UNIT=4'hD)
- the key table as a function ir_code_to_key returning {hit, key_id}
REQ-034 The queue is a separate sub-module, key_fifo, parameterised by width and depth.
REQ-035 All state is clocked on posedge clk and uses only the asynchronous rst_n.

Verification
REQ-036 Single key:
- Stimulus: press 0->1 with code=0x5E at cycle N, key_ready=0.
- Required: key_valid=1 and key_id=3 at N+3, level=1.
REQ-037 No retrigger:
- Stimulus: press held high 100000 cycles with code toggling 0x16/0x0C.
- Required: exactly one entry (key 0); the second edge after press falls yields key 1.
REQ-038 Unmapped code:
- Stimulus: code=0x99 pressed 3 times.
- Required: level=0, unk_cnt=3, key_valid never high.
- Saturation: preload to 255 via 300 presses, unk_cnt stays 255.
REQ-039 Overflow:
- Stimulus: 5 digit presses (1..5), key_ready=0, depth 4.
- Required: level=4, ovf=1, pops return 1,2,3,4; ovf_clr then ovf=0.
- Full plus same-cycle pop: level stays 4, ovf stays 0.
REQ-040 Reset mid-operation:
- Stimulus: assert rst_n low in the PUSH cycle of key 7 with 2 keys queued.
- Required: all outputs 0 immediately; after release, a new press of 0x40 gives key_id=C.
